// File: rtl/popcount_pkg.sv
// Shared sizing helpers for the streaming popcount pipeline.
// Widths, tree depth and per-stage element counts are all derived from these.
package popcount_pkg;

  function automatic int unsigned pc_w(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

  function automatic int unsigned tree_stages(input int unsigned nch);
    return $clog2(nch);
  endfunction

  function automatic int unsigned stage_len(input int unsigned nch, input int unsigned s);
    return (nch + (1 << s) - 1) >> s;
  endfunction

  // Partial-sum width at stage s: chunk count width plus one bit per adder level,
  // capped at the full result width.
  function automatic int unsigned stage_w(input int unsigned chunk, input int unsigned width,
                                          input int unsigned s);
    int unsigned w;
    w = pc_w(chunk) + s;
    return (w < pc_w(width)) ? w : pc_w(width);
  endfunction

endpackage

// File: rtl/popcount_chunk.sv
// Combinational population count of one CHUNK-bit slice.
module popcount_chunk
  import popcount_pkg::*;
#(
  parameter int unsigned CHUNK = 8,
  localparam int unsigned CW = pc_w(CHUNK)
) (
  input  logic [CHUNK-1:0] data_i,
  output logic [CW-1:0]    cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < CHUNK; i++) begin
      cnt_o = cnt_o + CW'(data_i[i]);
    end
  end

endmodule

// File: rtl/popcount_stream.sv
// Pipelined streaming popcount with valid/ready handshake and ones/zeros mode.
// Stage 0 counts chunks; following stages form a pairwise adder tree under one global enable.
module popcount_stream
  import popcount_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 8,
  localparam int unsigned CNT_W = pc_w(WIDTH)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             zeros_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             valid_o,
  input  logic             ready_i
);

  localparam int unsigned NCH = WIDTH / CHUNK;
  localparam int unsigned LAT = 1 + tree_stages(NCH);

  if (WIDTH < 2) begin : g_bad_width
    $error("popcount_stream: WIDTH must be at least 2");
  end
  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("popcount_stream: WIDTH must be a multiple of CHUNK");
  end

  logic [LAT-1:0]   valid_q, valid_d;
  logic             stall;
  logic             accept;
  logic [WIDTH-1:0] word;

  // Stall depends only on registered state and ready_i, never on valid_i.
  assign stall   = valid_q[LAT-1] && !ready_i;
  assign ready_o = !stall;
  assign accept  = valid_i && ready_o;
  assign word    = zeros_i ? ~data_i : data_i;

  always_comb begin
    valid_d    = valid_q;
    valid_d[0] = accept;
    for (int s = 1; s < LAT; s++) begin
      valid_d[s] = valid_q[s-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      valid_q <= '0;
    end else if (!stall) begin
      valid_q <= valid_d;
    end
  end

  for (genvar s = 0; s < LAT; s++) begin : g_stage
    localparam int unsigned Len = stage_len(NCH, s);
    localparam int unsigned W   = stage_w(CHUNK, WIDTH, s);

    logic [Len-1:0][W-1:0] sum_d, sum_q;

    if (s == 0) begin : g_chunks
      for (genvar k = 0; k < NCH; k++) begin : g_chunk
        popcount_chunk #(
          .CHUNK(CHUNK)
        ) u_chunk (
          .data_i(word[k*CHUNK +: CHUNK]),
          .cnt_o (sum_d[k])
        );
      end
    end else begin : g_add
      localparam int unsigned PrevLen = stage_len(NCH, s - 1);
      for (genvar i = 0; i < Len; i++) begin : g_elem
        if (2 * i + 1 < PrevLen) begin : g_pair
          assign sum_d[i] = W'(g_stage[s-1].sum_q[2*i]) + W'(g_stage[s-1].sum_q[2*i+1]);
        end else begin : g_fwd
          // Odd element count: the last partial sum passes through untouched.
          assign sum_d[i] = W'(g_stage[s-1].sum_q[2*i]);
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (srst_i) begin
        sum_q <= '0;
      end else if (!stall) begin
        sum_q <= sum_d;
      end
    end
  end

  assign cnt_o   = CNT_W'(g_stage[LAT-1].sum_q[0]);
  assign valid_o = valid_q[LAT-1];

endmodule

// File: tb/tb_popcount_stream.sv
// Directed and scoreboarded checks of popcount_stream across four configurations.
module tb_popcount_stream;

  localparam int NBEATS = 10000;
  localparam int MAXCYC = 60000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic srst_a = 1'b1;
  logic srst   = 1'b1;

  // a: 16/4 (LAT 3), b: 24/8 (LAT 3, odd tree), c: 64/8 (LAT 4), d: 16/16 (LAT 1)
  logic [15:0] a_data = '0;
  logic        a_zeros = 1'b0, a_valid = 1'b0, a_rdy = 1'b1, a_ready, a_vout;
  logic [4:0]  a_cnt;
  logic [23:0] b_data = '0;
  logic        b_zeros = 1'b0, b_valid = 1'b0, b_rdy = 1'b1, b_ready, b_vout;
  logic [5:0]  b_cnt;
  logic [63:0] c_data = '0;
  logic        c_zeros = 1'b0, c_valid = 1'b0, c_rdy = 1'b1, c_ready, c_vout;
  logic [6:0]  c_cnt;
  logic [15:0] d_data = '0;
  logic        d_zeros = 1'b0, d_valid = 1'b0, d_rdy = 1'b1, d_ready, d_vout;
  logic [4:0]  d_cnt;

  popcount_stream #(.WIDTH(16), .CHUNK(4)) u_dut_a (
    .clk_i(clk), .srst_i(srst_a), .data_i(a_data), .zeros_i(a_zeros), .valid_i(a_valid),
    .ready_o(a_ready), .cnt_o(a_cnt), .valid_o(a_vout), .ready_i(a_rdy)
  );
  popcount_stream #(.WIDTH(24), .CHUNK(8)) u_dut_b (
    .clk_i(clk), .srst_i(srst), .data_i(b_data), .zeros_i(b_zeros), .valid_i(b_valid),
    .ready_o(b_ready), .cnt_o(b_cnt), .valid_o(b_vout), .ready_i(b_rdy)
  );
  popcount_stream #(.WIDTH(64), .CHUNK(8)) u_dut_c (
    .clk_i(clk), .srst_i(srst), .data_i(c_data), .zeros_i(c_zeros), .valid_i(c_valid),
    .ready_o(c_ready), .cnt_o(c_cnt), .valid_o(c_vout), .ready_i(c_rdy)
  );
  popcount_stream #(.WIDTH(16), .CHUNK(16)) u_dut_d (
    .clk_i(clk), .srst_i(srst), .data_i(d_data), .zeros_i(d_zeros), .valid_i(d_valid),
    .ready_o(d_ready), .cnt_o(d_cnt), .valid_o(d_vout), .ready_i(d_rdy)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] t2_data [4] = '{16'h0001, 16'h8421, 16'h0000, 16'hAAAA};
  logic        t2_z    [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  int          t2_exp  [4] = '{1, 4, 16, 8};
  logic [15:0] t3_data [5] = '{16'h0F00, 16'h7777, 16'h0001, 16'hFFFF, 16'h1234};
  logic        t3_z    [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  int          t3_exp  [5] = '{4, 12, 15, 0, 5};
  logic [23:0] t5_data [3] = '{24'hFFFFFF, 24'h800001, 24'h000000};
  logic        t5_z    [3] = '{1'b0, 1'b0, 1'b1};
  int          t5_exp  [3] = '{24, 2, 24};

  int bp_in, bp_out, c_acc, d_acc, cyc, sel;
  int qc[$];
  int qd[$];
  logic [63:0] r64, r64b;

  initial begin
    step();
    step();
    srst_a = 1'b0;
    srst   = 1'b0;

    // Reset state, then one all-ones beat and its latency.
    a_data = 16'hFFFF; a_zeros = 1'b0; a_valid = 1'b1;
    #1;
    check("rst_valid", a_vout, 0);
    check("rst_cnt", a_cnt, 0);
    check("rst_ready", a_ready, 1);
    check("rst_c_valid", c_vout, 0);
    check("rst_d_ready", d_ready, 1);
    step();
    a_valid = 1'b0;
    #1;
    check("t1_lat0", a_vout, 0);
    step(); #1;
    check("t1_lat1", a_vout, 0);
    step(); #1;
    check("t1_valid", a_vout, 1);
    check("t1_cnt", a_cnt, 16);
    step(); #1;
    check("t1_after", a_vout, 0);
    step();

    // Back-to-back beats, no gaps.
    for (int c = 0; c < 8; c++) begin
      a_valid = (c < 4);
      if (c < 4) begin
        a_data = t2_data[c]; a_zeros = t2_z[c];
      end
      #1;
      check("t2_valid", a_vout, (c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) check("t2_cnt", a_cnt, t2_exp[c-3]);
      step();
    end
    a_valid = 1'b0; a_zeros = 1'b0;

    // Backpressure: ready_i low for four cycles while a result is waiting.
    bp_in = 0; bp_out = 0;
    for (int c = 0; c < 24; c++) begin
      a_valid = (bp_in < 5);
      if (bp_in < 5) begin
        a_data = t3_data[bp_in]; a_zeros = t3_z[bp_in];
      end
      a_rdy = !(c >= 4 && c < 8);
      #1;
      if (a_vout) begin
        if (bp_out < 5) check("t3_cnt", a_cnt, t3_exp[bp_out]);
        else check("t3_dup", a_vout, 0);
        if (!a_rdy) check("t3_ready_low", a_ready, 0);
        else bp_out++;
      end
      if (a_valid && a_ready) bp_in++;
      step();
    end
    check("t3_in", bp_in, 5);
    check("t3_out", bp_out, 5);
    a_rdy = 1'b1; a_valid = 1'b0; a_zeros = 1'b0;

    // Reset mid-flight; the beat offered during reset must not be taken.
    for (int c = 0; c < 12; c++) begin
      srst_a  = (c == 2);
      a_valid = (c <= 2 || c == 4);
      a_data  = (c == 0) ? 16'h00FF : (c == 1) ? 16'h0F0F : (c == 2) ? 16'hFFFF : 16'h0003;
      #1;
      check("t4_valid", a_vout, (c == 7));
      if (c == 7) check("t4_cnt", a_cnt, 2);
      step();
    end
    a_valid = 1'b0;

    // Odd tree on the 24-bit instance.
    for (int c = 0; c < 7; c++) begin
      b_valid = (c < 3);
      if (c < 3) begin
        b_data = t5_data[c]; b_zeros = t5_z[c];
      end
      #1;
      check("t5_valid", b_vout, (c >= 3 && c <= 5));
      if (c >= 3 && c <= 5) check("t5_cnt", b_cnt, t5_exp[c-3]);
      step();
    end
    b_valid = 1'b0;

    // Random valid/ready with in-order scoreboards on the 64/8 and 16/16 instances.
    c_acc = 0; d_acc = 0; cyc = 0;
    while ((c_acc < NBEATS || d_acc < NBEATS || qc.size() > 0 || qd.size() > 0)
           && cyc < MAXCYC) begin
      r64 = {$urandom, $urandom};
      sel = $urandom_range(0, 15);
      if (sel == 0) r64 = '1;
      else if (sel == 1) r64 = '0;
      r64b = {$urandom, $urandom};
      c_valid = (c_acc < NBEATS) && ($urandom_range(0, 3) != 0);
      c_data  = r64;
      c_zeros = 1'($urandom_range(0, 1));
      c_rdy   = ($urandom_range(0, 3) != 0);
      d_valid = (d_acc < NBEATS) && ($urandom_range(0, 3) != 0);
      d_data  = (sel == 2) ? 16'hFFFF : r64b[15:0];
      d_zeros = 1'($urandom_range(0, 1));
      d_rdy   = ($urandom_range(0, 3) != 0);
      #1;
      if (c_valid && c_ready) begin
        qc.push_back(c_zeros ? $countones(~c_data) : $countones(c_data));
        c_acc++;
      end
      if (d_valid && d_ready) begin
        qd.push_back(d_zeros ? $countones(~d_data) : $countones(d_data));
        d_acc++;
      end
      if (c_vout && c_rdy) begin
        check("c_sb_nonempty", (qc.size() != 0), 1);
        if (qc.size() != 0) check("c_cnt", c_cnt, qc.pop_front());
      end
      if (d_vout && d_rdy) begin
        check("d_sb_nonempty", (d_vout && qd.size() != 0), 1);
        if (qd.size() != 0) check("d_cnt", d_cnt, qd.pop_front());
      end
      step();
      cyc++;
    end
    check("rnd_within_budget", (cyc < MAXCYC), 1);
    check("rnd_c_beats", c_acc, NBEATS);
    check("rnd_d_beats", d_acc, NBEATS);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
